pacman_move_arbiter: RTL
========================

// Module: pacman_move_arbiter
// PURPOSE
//  Sits between keyboard_process and map_RAM_writer. On each move tick, turns up/down/left/right
//  into a legal single-tile Pac-Man step. Legality is checked against the map RAM row
//  (160b = 40 tiles x 4b; tile x at bits [159-4x -: 4]).
//  Hands {curr,next} to the writer with a valid/done handshake; counts pellets eaten.
// PARAMETERS
//  MOVE_DIV  2_500_000  CLOCK_50 cycles per move tick (20 moves/s)
//  START_X   19         reset tile column (0..COLS-1)
//  START_Y   23         reset tile row (0..ROWS-1)
//  COLS      40         tiles per row
//  ROWS      30         rows in map RAM
// PORTS
//  CLOCK_50       in   1    system clock
//  reset_n        in   1    asynchronous, active-low reset
//  up,down,left,right in 1 each  level direction requests from keyboard_process
//  rd_addr        out  5    map RAM read row address
//  rd_data        in   160  map RAM row; valid 1 cycle after rd_addr is sampled
//  move_valid     out  1    move request to writer, held until done
//  done           in   1    1-cycle pulse from writer: map updated
//  curr_pacman_x  out  6    current tile column
//  curr_pacman_y  out  5    current tile row
//  next_pacman_x  out  6    target tile column (stable while move_valid)
//  next_pacman_y  out  5    target tile row (stable while move_valid)
//  pellet_eaten   out  1    1-cycle pulse when a committed move lands on PELLET
//  score          out  14   saturating pellet count
// BEHAVIOUR
//  Reset: curr=next=(START_X,START_Y); heading=NONE; move_valid=0; rd_addr=0; pellet_eaten=0;
//   score=0; tick counter=0; FSM=IDLE.
//  Tick: counter counts 0..MOVE_DIV-1 and pulses at wrap. A tick outside IDLE is dropped.
//  Candidate priority: up>down>left>right. Offsets: up y-1, down y+1, left x-1, right x+1.
//  FSM:
//   IDLE  -> tick & (any key | heading!=NONE) -> CAND: dir=pressed key, else heading.
//   CAND  compute target from curr+dir, drive rd_addr=target_y -> WAIT.
//   WAIT  one RAM-latency cycle -> CHECK.
//   CHECK tile=rd_data[159-4*tx -: 4]. Outcomes:
//         tile!=WALL & in range: next=target, heading=dir -> REQ.
//         blocked & dir!=heading & heading!=NONE: dir=heading -> CAND (one retry).
//         otherwise: heading=NONE -> IDLE.
//   REQ   move_valid=1, next held. On done: curr<=next; move_valid<=0.
//         If the checked tile was PELLET, pellet_eaten pulses and score+1 (saturates 16383) -> IDLE.
//  done seen outside REQ is ignored.
//  Boundaries:
//   y=0 up / y=ROWS-1 down: blocked, no RAM read needed but the path is the same.
//   x=0 left / x=COLS-1 right: see TUNNEL_WRAP_EN.
//  Simultaneous tick & done in REQ: the done completes; the tick is dropped.
//  Reset mid-REQ: move_valid drops asynchronously; the writer must tolerate an abandoned request.
//  Width: target arithmetic in 7b signed; range-checked before truncation.
// CONFIGURATION
//  PACMAN_TUNNEL_WRAP_EN defined: left from x=0 targets x=COLS-1; right from x=COLS-1 targets x=0.
//   The wall check still applies.
//  Undefined: horizontal edge moves are blocked exactly like vertical ones.
// STRUCTURE
//  pacman_pkg: tile_t enum (EMPTY=4'h0, WALL=4'h1, PELLET=4'h2, PACMAN=4'h3);
//   dir_t enum (NONE, UP, DOWN, LEFT, RIGHT); MAP_COLS=40; MAP_ROWS=30.
//  Sub-module move_tick_gen (parameter DIV; ports CLOCK_50, reset_n, tick).
//  The FSM, target/tile logic and score stay in this module.
// TESTING (MOVE_DIV=4 in sim; RAM model with 1-cycle read latency)
//  Reset at (19,23), right held, tile (20,23)=EMPTY:
//   -> move_valid with next=(20,23); done -> curr=(20,23); score=0.
//  Up held, tile (19,22)=PELLET:
//   -> move commits; pellet_eaten 1 cycle; score=1.
//  Heading RIGHT, up pressed, (x,y-1)=WALL, (x+1,y)=EMPTY:
//   -> retry taken, next=(x+1,y), heading stays RIGHT.
//  Both candidates WALL -> no move_valid, heading=NONE.
//   With no key held, the next tick does nothing.
//  curr=(0,10), left held, (39,10)=EMPTY:
//   -> with PACMAN_TUNNEL_WRAP_EN next=(39,10); without, no move.
//  Assert reset_n=0 while move_valid=1, and hold done low over 3 ticks:
//   -> outputs return to reset values immediately; no curr update, no tick accepted while in REQ.

Source files
------------

// File: rtl/pacman_pkg.sv
// pacman_pkg: shared tile/direction encodings and map geometry for the Pac-Man datapath
package pacman_pkg;
    localparam int MAP_COLS = 40;
    localparam int MAP_ROWS = 30;
    typedef enum logic [3:0] {EMPTY = 4'h0, WALL = 4'h1, PELLET = 4'h2, PACMAN = 4'h3} tile_t;
    typedef enum logic [2:0] {NONE, UP, DOWN, LEFT, RIGHT} dir_t;
endpackage

// File: rtl/move_tick_gen.sv
// move_tick_gen: free-running divider, one-cycle tick every DIV clocks
module move_tick_gen #(
    parameter int DIV = 2_500_000
) (
    input  logic CLOCK_50,
    input  logic reset_n,
    output logic tick
);
    localparam int W = DIV > 1 ? $clog2(DIV) : 1;
    logic [W-1:0] cnt;
    assign tick = cnt == W'(DIV - 1);
    always_ff @(posedge CLOCK_50 or negedge reset_n)
        if (!reset_n) cnt <= '0;
        else          cnt <= tick ? '0 : cnt + W'(1);
endmodule

// File: rtl/pacman_move_arbiter.sv
// pacman_move_arbiter: turns key requests into legal one-tile moves; PACMAN_TUNNEL_WRAP_EN wraps horizontal edges
module pacman_move_arbiter
    import pacman_pkg::*;
#(
    parameter int MOVE_DIV = 2_500_000,
    parameter int START_X  = 19,
    parameter int START_Y  = 23,
    parameter int COLS     = MAP_COLS,
    parameter int ROWS     = MAP_ROWS
) (
    input  logic         CLOCK_50,
    input  logic         reset_n,
    input  logic         up,
    input  logic         down,
    input  logic         left,
    input  logic         right,
    output logic [4:0]   rd_addr,
    input  logic [159:0] rd_data,
    output logic         move_valid,
    input  logic         done,
    output logic [5:0]   curr_pacman_x,
    output logic [4:0]   curr_pacman_y,
    output logic [5:0]   next_pacman_x,
    output logic [4:0]   next_pacman_y,
    output logic         pellet_eaten,
    output logic [13:0]  score
);
    typedef enum logic [2:0] {S_IDLE, S_CAND, S_WAIT, S_CHECK, S_REQ} state_t;
    localparam logic signed [6:0] C7 = 7'(COLS);
    localparam logic signed [6:0] R7 = 7'(ROWS);

    state_t state, state_n;
    dir_t heading, dir, key_dir;
    logic tick, go, blocked, retry, eat, tgt_ok, tgt_in;
    logic signed [6:0] dx, dy, tx_raw, tx, ty;
    logic [5:0] tgt_x;
    logic [4:0] tgt_y;
    logic [159:0] row_sh;
    tile_t tile;

    move_tick_gen #(.DIV(MOVE_DIV)) u_tick (
        .CLOCK_50(CLOCK_50),
        .reset_n (reset_n),
        .tick    (tick)
    );

    assign key_dir = up ? UP : down ? DOWN : left ? LEFT : right ? RIGHT : NONE;
    assign go      = tick && (key_dir != NONE || heading != NONE);

    assign dx     = dir == LEFT ? -7'sd1 : dir == RIGHT ? 7'sd1 : 7'sd0;
    assign dy     = dir == UP ? -7'sd1 : dir == DOWN ? 7'sd1 : 7'sd0;
    assign tx_raw = $signed({1'b0, curr_pacman_x}) + dx;
    assign ty     = $signed({2'b00, curr_pacman_y}) + dy;
`ifdef PACMAN_TUNNEL_WRAP_EN
    assign tx = tx_raw < 7'sd0 ? C7 - 7'sd1 : tx_raw >= C7 ? 7'sd0 : tx_raw;
`else
    assign tx = tx_raw;
`endif
    assign tgt_in = tx >= 7'sd0 && tx < C7 && ty >= 7'sd0 && ty < R7;

    // Tile x lives at bits [159-4x -: 4]; shifting left by 4x brings it to the top nibble.
    assign row_sh  = rd_data << {tgt_x, 2'b00};
    assign tile    = tile_t'(row_sh[159:156]);
    assign blocked = !tgt_ok || tile == WALL;
    assign retry   = dir != heading && heading != NONE;

    assign move_valid = state == S_REQ;

    always_ff @(posedge CLOCK_50 or negedge reset_n)
        if (!reset_n) state <= S_IDLE;
        else          state <= state_n;

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  state_n = go ? S_CAND : S_IDLE;
            S_CAND:  state_n = S_WAIT;
            S_WAIT:  state_n = S_CHECK;
            S_CHECK: state_n = !blocked ? S_REQ : retry ? S_CAND : S_IDLE;
            S_REQ:   state_n = done ? S_IDLE : S_REQ;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n)
        if (!reset_n) begin
            curr_pacman_x <= 6'(START_X);
            curr_pacman_y <= 5'(START_Y);
            next_pacman_x <= 6'(START_X);
            next_pacman_y <= 5'(START_Y);
            heading       <= NONE;
            dir           <= NONE;
            tgt_x         <= '0;
            tgt_y         <= '0;
            tgt_ok        <= 1'b0;
            rd_addr       <= '0;
            eat           <= 1'b0;
            pellet_eaten  <= 1'b0;
            score         <= '0;
        end else begin
            pellet_eaten <= 1'b0;
            case (state)
                S_IDLE: if (go) dir <= key_dir != NONE ? key_dir : heading;
                S_CAND: begin
                    tgt_x   <= tx[5:0];
                    tgt_y   <= ty[4:0];
                    tgt_ok  <= tgt_in;
                    rd_addr <= tgt_in ? ty[4:0] : curr_pacman_y;
                end
                S_CHECK:
                    if (!blocked) begin
                        next_pacman_x <= tgt_x;
                        next_pacman_y <= tgt_y;
                        heading       <= dir;
                        eat           <= tile == PELLET;
                    end else if (retry) dir <= heading;
                    else heading <= NONE;
                S_REQ:
                    if (done) begin
                        curr_pacman_x <= next_pacman_x;
                        curr_pacman_y <= next_pacman_y;
                        if (eat) begin
                            pellet_eaten <= 1'b1;
                            score        <= &score ? score : score + 14'd1;
                        end
                    end
                default: ;
            endcase
        end
endmodule
